// File: rtl/ex_mem_stage.sv
// Execute-to-memory pipeline stage with a 2-entry skid buffer.
// The main register drives the mem_* outputs. The skid register catches the
// one entry that can arrive while the memory stage is stalling. Handshake
// outputs are decoded from registered state only, so a stall from the memory
// stage never reaches the execute stage combinationally.
//
//   state   | meaning
//   --------+-------------------------------------------
//   S_EMPTY | no entry held; mem_valid=0, ex_ready=1
//   S_ONE   | main holds an entry; mem_valid=1, ex_ready=1
//   S_TWO   | main and skid full; mem_valid=1, ex_ready=0
module ex_mem_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          flush,
  input  logic          ex_valid,
  output logic          ex_ready,
  input  logic [DW-1:0] alu_o,
  input  logic          alu_n,
  input  logic          alu_z,
  input  logic          alu_v,
  input  logic [RW-1:0] ex_rd,
  input  logic          ex_regwen,
  input  logic          ex_memren,
  input  logic          ex_memwen,
  input  logic          ex_trapovf,
  input  logic [DW-1:0] ex_sdata,
  output logic          mem_valid,
  input  logic          mem_ready,
  output logic [DW-1:0] mem_result,
  output logic          mem_n,
  output logic          mem_z,
  output logic          mem_v,
  output logic [RW-1:0] mem_rd,
  output logic          mem_regwen,
  output logic          mem_memren,
  output logic          mem_memwen,
  output logic [DW-1:0] mem_sdata,
  output logic          ovf_exc
);

  // Entry layout, LSB first: result, n, z, v, rd, regwen, memren, memwen, sdata, trap
  localparam int P_N    = DW;
  localparam int P_Z    = DW + 1;
  localparam int P_V    = DW + 2;
  localparam int P_RD   = DW + 3;
  localparam int P_RWEN = DW + 3 + RW;
  localparam int P_MREN = DW + 4 + RW;
  localparam int P_MWEN = DW + 5 + RW;
  localparam int P_SD   = DW + 6 + RW;
  localparam int P_TRAP = 2*DW + 6 + RW;
  localparam int EW     = 2*DW + 7 + RW;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [EW-1:0] r_main;
  logic [EW-1:0] r_skid;
  logic [EW-1:0] w_in;
  logic          w_trap_in;
  logic          w_accept;
  logic          w_issue;

  // A trapped instruction keeps its result and flags but loses all side effects.
  assign w_trap_in = ex_trapovf & alu_v;
  assign w_in = {w_trap_in, ex_sdata,
                 ex_memwen & ~w_trap_in, ex_memren & ~w_trap_in, ex_regwen & ~w_trap_in,
                 ex_rd, alu_v, alu_z, alu_n, alu_o};

  assign w_accept = ex_valid & (r_state != S_TWO);
  assign w_issue  = (r_state != S_EMPTY) & mem_ready;

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_EMPTY;
    else     r_state <= w_next;
  end

  // Next-state logic; flush overrides every transfer
  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = S_EMPTY;
    end else begin
      unique case (r_state)
        S_EMPTY: if (w_accept) w_next = S_ONE;
        S_ONE: begin
          if (w_accept && !w_issue)      w_next = S_TWO;
          else if (!w_accept && w_issue) w_next = S_EMPTY;
        end
        S_TWO:   if (w_issue) w_next = S_ONE;
        default: w_next = S_EMPTY;
      endcase
    end
  end

  // Entry storage: main reloads only on accept into an empty slot or on issue
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_main <= '0;
      r_skid <= '0;
    end else if (!flush) begin
      unique case (r_state)
        S_EMPTY: if (w_accept) r_main <= w_in;
        S_ONE: begin
          if (w_accept && w_issue) r_main <= w_in;
          else if (w_accept)       r_skid <= w_in;
        end
        S_TWO:   if (w_issue) r_main <= r_skid;
        default: ;
      endcase
    end
  end

  // Handshake and exception outputs from registered state
  always_comb begin
    mem_valid = (r_state != S_EMPTY);
    ex_ready  = (r_state != S_TWO);
    ovf_exc   = w_issue & r_main[P_TRAP] & ~flush;
  end

  assign mem_result = r_main[DW-1:0];
  assign mem_n      = r_main[P_N];
  assign mem_z      = r_main[P_Z];
  assign mem_v      = r_main[P_V];
  assign mem_rd     = r_main[P_RD +: RW];
  assign mem_regwen = r_main[P_RWEN];
  assign mem_memren = r_main[P_MREN];
  assign mem_memwen = r_main[P_MWEN];
  assign mem_sdata  = r_main[P_SD +: DW];

endmodule

// File: tb/tb_ex_mem_stage.sv
module tb_ex_mem_stage;
  logic        CLK = 1'b0;
  logic        RST;
  logic        flush;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] alu_o;
  logic        alu_n, alu_z, alu_v;
  logic [4:0]  ex_rd;
  logic        ex_regwen, ex_memren, ex_memwen, ex_trapovf;
  logic [31:0] ex_sdata;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_result;
  logic        mem_n, mem_z, mem_v;
  logic [4:0]  mem_rd;
  logic        mem_regwen, mem_memren, mem_memwen;
  logic [31:0] mem_sdata;
  logic        ovf_exc;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [31:0] res;
    logic        n, z, v;
    logic [4:0]  rd;
    logic        rw, mr, mw;
    logic [31:0] sd;
    logic        trap;
  } ent_t;

  ent_t q[$];

  ex_mem_stage #(.DW(32), .RW(5)) dut (
    .CLK(CLK), .RST(RST), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .alu_o(alu_o), .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v),
    .ex_rd(ex_rd), .ex_regwen(ex_regwen), .ex_memren(ex_memren),
    .ex_memwen(ex_memwen), .ex_trapovf(ex_trapovf), .ex_sdata(ex_sdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_result(mem_result), .mem_n(mem_n), .mem_z(mem_z), .mem_v(mem_v),
    .mem_rd(mem_rd), .mem_regwen(mem_regwen), .mem_memren(mem_memren),
    .mem_memwen(mem_memwen), .mem_sdata(mem_sdata), .ovf_exc(ovf_exc)
  );

  always #5 CLK = ~CLK;

  task automatic drive(input logic v, input logic [31:0] o, input logic n, input logic z,
                       input logic ovf, input logic [4:0] rd, input logic rw, input logic mr,
                       input logic mw, input logic tr, input logic [31:0] sd);
    ex_valid = v; alu_o = o; alu_n = n; alu_z = z; alu_v = ovf; ex_rd = rd;
    ex_regwen = rw; ex_memren = mr; ex_memwen = mw; ex_trapovf = tr; ex_sdata = sd;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; flush = 1'b0; mem_ready = 1'b1; idle();
    #12;
    n_total++; if (mem_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", mem_valid); else n_pass++;
    n_total++; if (ex_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", ex_ready); else n_pass++;
    n_total++; if (ovf_exc !== 1'b0) $display("FAIL reset_ovf got %b exp 0", ovf_exc); else n_pass++;
    n_total++;
    if ({mem_result, mem_sdata, mem_rd, mem_regwen, mem_memren, mem_memwen, mem_n, mem_z, mem_v} !== '0)
      $display("FAIL reset_data got result %h sdata %h rd %0d", mem_result, mem_sdata, mem_rd);
    else n_pass++;
    @(posedge CLK); #3 RST = 1'b0;
  endtask

  task automatic test_stream();
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (i > 0) begin
        n_total++;
        if (mem_valid !== 1'b1 || mem_result !== 32'(i))
          $display("FAIL stream_result got v=%b %h exp v=1 %h", mem_valid, mem_result, 32'(i));
        else n_pass++;
      end
      n_total++; if (ex_ready !== 1'b1) $display("FAIL stream_ready got %b exp 1", ex_ready); else n_pass++;
      drive(1'b1, 32'(i + 1), 1'b0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    end
    step(); idle();
    n_total++;
    if (mem_valid !== 1'b1 || mem_result !== 32'd4) $display("FAIL stream_last got v=%b %h exp v=1 4", mem_valid, mem_result);
    else n_pass++;
    step();
    n_total++; if (mem_valid !== 1'b0) $display("FAIL stream_drain got %b exp 0", mem_valid); else n_pass++;
  endtask

  task automatic test_backpressure();
    mem_ready = 1'b0;
    step(); drive(1'b1, 32'hA, 1'b0, 1'b0, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    n_total++;
    if (mem_valid !== 1'b1 || ex_ready !== 1'b1 || mem_result !== 32'hA)
      $display("FAIL bp_one got v=%b r=%b %h exp v=1 r=1 a", mem_valid, ex_ready, mem_result);
    else n_pass++;
    drive(1'b1, 32'hB, 1'b0, 1'b0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step(); idle();
    n_total++;
    if (ex_ready !== 1'b0 || mem_result !== 32'hA) $display("FAIL bp_two got r=%b %h exp r=0 a", ex_ready, mem_result);
    else n_pass++;
    step();
    n_total++;
    if (ex_ready !== 1'b0 || mem_result !== 32'hA || mem_rd !== 5'd1)
      $display("FAIL bp_hold got r=%b %h rd %0d exp r=0 a rd 1", ex_ready, mem_result, mem_rd);
    else n_pass++;
    mem_ready = 1'b1;
    step();
    n_total++;
    if (mem_valid !== 1'b1 || ex_ready !== 1'b1 || mem_result !== 32'hB)
      $display("FAIL bp_second got v=%b r=%b %h exp v=1 r=1 b", mem_valid, ex_ready, mem_result);
    else n_pass++;
    step();
    n_total++; if (mem_valid !== 1'b0) $display("FAIL bp_drain got %b exp 0", mem_valid); else n_pass++;
  endtask

  task automatic test_trap();
    int pulses;
    for (int t = 1; t >= 0; t--) begin
      pulses = 0;
      mem_ready = 1'b0;
      step(); drive(1'b1, 32'h80000000, 1'b1, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b1, t[0], 32'h55);
      step(); idle(); #1;
      if (ovf_exc === 1'b1) pulses++;
      n_total++;
      if (mem_regwen !== ~t[0] || mem_memwen !== ~t[0] || mem_v !== 1'b1 || mem_result !== 32'h80000000)
        $display("FAIL trap%0d_ctrl got rw=%b mw=%b v=%b %h exp rw=%b mw=%b v=1 80000000",
                 t, mem_regwen, mem_memwen, mem_v, mem_result, ~t[0], ~t[0]);
      else n_pass++;
      step(); if (ovf_exc === 1'b1) pulses++;
      mem_ready = 1'b1; #1;
      n_total++; if (ovf_exc !== t[0]) $display("FAIL trap%0d_issue got %b exp %b", t, ovf_exc, t[0]); else n_pass++;
      if (ovf_exc === 1'b1) pulses++;
      step(); if (ovf_exc === 1'b1) pulses++;
      step(); if (ovf_exc === 1'b1) pulses++;
      n_total++; if (pulses !== t) $display("FAIL trap%0d_pulses got %0d exp %0d", t, pulses, t); else n_pass++;
    end
  endtask

  task automatic test_flush();
    mem_ready = 1'b0;
    step(); drive(1'b1, 32'h111, 1'b0, 1'b0, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
    step(); drive(1'b1, 32'h222, 1'b0, 1'b0, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
    step();
    n_total++; if (ex_ready !== 1'b0) $display("FAIL flush_pre got ready %b exp 0", ex_ready); else n_pass++;
    drive(1'b1, 32'h333, 1'b0, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
    flush = 1'b1; mem_ready = 1'b1; #1;
    n_total++; if (ovf_exc !== 1'b0) $display("FAIL flush_ovf got %b exp 0", ovf_exc); else n_pass++;
    step(); flush = 1'b0; idle();
    n_total++;
    if (mem_valid !== 1'b0 || ex_ready !== 1'b1) $display("FAIL flush_after got v=%b r=%b exp v=0 r=1", mem_valid, ex_ready);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      step();
      n_total++;
      if (mem_valid !== 1'b0 || ovf_exc !== 1'b0) $display("FAIL flush_quiet got v=%b ovf=%b exp 0 0", mem_valid, ovf_exc);
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    mem_ready = 1'b0;
    step(); drive(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step(); idle();
    n_total++;
    if (mem_valid !== 1'b1 || mem_result !== 32'hDEADBEEF) $display("FAIL arst_pre got v=%b %h exp v=1 deadbeef", mem_valid, mem_result);
    else n_pass++;
    #2 RST = 1'b1;
    #1;
    n_total++;
    if (mem_valid !== 1'b0 || mem_result !== 32'h0 || ex_ready !== 1'b1)
      $display("FAIL arst_now got v=%b r=%b %h exp v=0 r=1 0", mem_valid, ex_ready, mem_result);
    else n_pass++;
    step(); #2 RST = 1'b0;
    mem_ready = 1'b1;
    step(); drive(1'b1, 32'h5, 1'b0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step(); idle();
    n_total++;
    if (mem_valid !== 1'b1 || mem_result !== 32'h5) $display("FAIL arst_after got v=%b %h exp v=1 5", mem_valid, mem_result);
    else n_pass++;
    step();
  endtask

  task automatic test_flags();
    mem_ready = 1'b1;
    step(); drive(1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step(); drive(1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    n_total++;
    if (mem_z !== 1'b1 || mem_n !== 1'b0) $display("FAIL flags_zero got z=%b n=%b exp z=1 n=0", mem_z, mem_n);
    else n_pass++;
    step(); idle();
    n_total++;
    if (mem_z !== 1'b0 || mem_n !== 1'b1 || mem_result !== 32'hFFFFFFFF)
      $display("FAIL flags_neg got z=%b n=%b %h exp z=0 n=1 ffffffff", mem_z, mem_n, mem_result);
    else n_pass++;
    step();
  endtask

  // Reference: a FIFO of at most two entries with trap conversion applied on entry
  task automatic test_random();
    logic p_acc, p_iss, p_flush, exp_ovf;
    ent_t p_ent, e;
    p_acc = 1'b0; p_iss = 1'b0; p_flush = 1'b0;
    p_ent = '{default: '0};
    step(); flush = 1'b1; idle();
    step(); flush = 1'b0;
    q.delete();
    for (int c = 0; c < 400; c++) begin
      if (c > 0) step();
      if (p_flush) q.delete();
      else begin
        if (p_iss) void'(q.pop_front());
        if (p_acc) q.push_back(p_ent);
      end
      n_total++;
      if (mem_valid !== (q.size() > 0) || ex_ready !== (q.size() < 2))
        $display("FAIL rnd_hs c%0d got v=%b r=%b exp depth %0d", c, mem_valid, ex_ready, q.size());
      else n_pass++;
      if (q.size() > 0) begin
        e = q[0];
        n_total++;
        if ({mem_result, mem_n, mem_z, mem_v, mem_rd, mem_regwen, mem_memren, mem_memwen, mem_sdata} !==
            {e.res, e.n, e.z, e.v, e.rd, e.rw, e.mr, e.mw, e.sd})
          $display("FAIL rnd_entry c%0d got %h rd%0d ctl%b%b%b exp %h rd%0d ctl%b%b%b", c, mem_result, mem_rd,
                   mem_regwen, mem_memren, mem_memwen, e.res, e.rd, e.rw, e.mr, e.mw);
        else n_pass++;
      end
      ex_valid = ($urandom_range(0, 3) != 0);
      mem_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 19) == 0);
      alu_o = $urandom; alu_n = 1'($urandom); alu_z = 1'($urandom); alu_v = 1'($urandom);
      ex_rd = 5'($urandom); ex_regwen = 1'($urandom); ex_memren = 1'($urandom);
      ex_memwen = 1'($urandom); ex_trapovf = 1'($urandom); ex_sdata = $urandom;
      #1;
      exp_ovf = (q.size() > 0) && mem_ready && q[0].trap && !flush;
      n_total++; if (ovf_exc !== exp_ovf) $display("FAIL rnd_ovf c%0d got %b exp %b", c, ovf_exc, exp_ovf); else n_pass++;
      p_acc = ex_valid && (q.size() < 2);
      p_iss = (q.size() > 0) && mem_ready;
      p_flush = flush;
      p_ent.trap = ex_trapovf && alu_v;
      p_ent.res = alu_o; p_ent.n = alu_n; p_ent.z = alu_z; p_ent.v = alu_v; p_ent.rd = ex_rd;
      p_ent.rw = ex_regwen && !p_ent.trap;
      p_ent.mr = ex_memren && !p_ent.trap;
      p_ent.mw = ex_memwen && !p_ent.trap;
      p_ent.sd = ex_sdata;
    end
    step(); flush = 1'b0; idle();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_trap();
    test_flush();
    test_async_reset();
    test_flags();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Execute-to-memory pipeline stage that sits directly downstream of the ALU.
- Captures the ALU result and its n/z/v flags, together with the instruction's writeback/memory control, behind a valid/ready handshake.
- Holds a 2-entry skid buffer, so a stall from the memory stage never combinationally reaches the execute stage.
- Converts overflowing trap-enabled instructions into killed bubbles and raises a one-cycle exception pulse.

Parameters:
- DW, 32, datapath width; matches word_t.
- RW, 5, register-index width.

Ports:
- CLK  in  1  clock; rising edge.
- RST  in  1  reset; asynchronous, active-high.
- flush  in  1  synchronous kill of all held and incoming entries.
- ex_valid  in  1  execute stage presents an entry.
- ex_ready  out  1  stage can accept; registered, equals !skid_full.
- alu_o  in  DW  ALU port_o.
- alu_n  in  1  ALU negative flag.
- alu_z  in  1  ALU zero flag.
- alu_v  in  1  ALU overflow flag.
- ex_rd  in  RW  destination register.
- ex_regwen  in  1  register write enable.
- ex_memren  in  1  memory read enable.
- ex_memwen  in  1  memory write enable.
- ex_trapovf  in  1  trap on overflow (signed add/sub).
- ex_sdata  in  DW  store data.
- mem_valid  out  1  output entry valid.
- mem_ready  in  1  memory stage accepts.
- mem_result  out  DW  held ALU result.
- mem_n  out  1  held negative flag.
- mem_z  out  1  held zero flag.
- mem_v  out  1  held overflow flag.
- mem_rd  out  RW  held destination register.
- mem_regwen  out  1  held register write enable.
- mem_memren  out  1  held memory read enable.
- mem_memwen  out  1  held memory write enable.
- mem_sdata  out  DW  held store data.
- ovf_exc  out  1  one-cycle pulse when a trapped entry is handed downstream.

Behaviour:
- Storage: main register drives the mem_* outputs; skid register holds one overflow entry.
- State machine: EMPTY (no entries), ONE (main only), TWO (main and skid). mem_valid = (state != EMPTY); ex_ready = (state != TWO); both are decoded from registered state only.
- Transfer rules:
  - accept = ex_valid & ex_ready.
  - issue = mem_valid & mem_ready.
- EMPTY:
  - accept → ONE; incoming entry loads main.
- ONE:
  - accept & issue → ONE; main reloads with the incoming entry.
  - accept & !issue → TWO; incoming entry loads skid.
  - !accept & issue → EMPTY.
  - Otherwise hold.
- TWO:
  - issue → ONE; skid moves to main.
  - Input cannot be accepted because ex_ready=0.
- Ordering: strictly FIFO; an entry never bypasses an older one.
- Trap conversion, applied at accept: if ex_trapovf & alu_v, the stored regwen, memren and memwen are forced to 0 and an internal trap bit is set. Result, flags and rd are stored unchanged.
- ovf_exc = issue & trap bit of main. Combinational from registered state, so it is high exactly one cycle per trapped entry. A held (stalled) trapped entry does not pulse until it is issued.
- Flush:
  - Has priority over everything; next state is EMPTY, and the incoming entry is dropped even if accept=1.
  - ovf_exc is suppressed in the flush cycle.
  - Issue still occurs in that cycle if mem_ready=1, since the downstream consumer saw mem_valid.
- No combinational path from any ex_* input to any mem_* output, or from mem_ready to ex_ready.
- Reset (RST=1, asynchronous), also mid-transfer:
  - state=EMPTY; all data/control registers and trap bits cleared.
  - mem_valid=0, ex_ready=1, ovf_exc=0, all mem_* outputs 0.
  - In-flight entries are discarded.
- Output stability: while mem_valid=1 and mem_ready=0, all mem_* outputs hold constant.

Test Plan:
- Stream: ex_valid=1 and mem_ready=1 held for 4 cycles with alu_o=1,2,3,4 → mem_result 1,2,3,4 on consecutive cycles, one cycle after input; ex_ready stays 1.
- Backpressure: mem_ready=0 while entries 0xA and 0xB are sent → state TWO, ex_ready=0, mem_result holds 0xA. Release mem_ready → 0xA then 0xB issued, ex_ready returns 1 after the first issue.
- Overflow trap: alu_o=0x80000000, alu_v=1, ex_trapovf=1, regwen=1, memwen=1 → mem_regwen=0, mem_memwen=0, mem_v=1. ovf_exc pulses exactly once, on the issue cycle. The same input with ex_trapovf=0 keeps regwen=1 and gives no pulse.
- Flush: in state TWO, assert flush with ex_valid=1 → next cycle mem_valid=0 and ex_ready=1; neither held entry nor the incoming entry ever appears; no ovf_exc.
- Async reset: assert RST mid-cycle in state ONE holding 0xDEADBEEF → mem_valid and mem_result are 0 immediately, before the next CLK edge. After release, the first accepted entry 0x5 appears normally.
- Flags passthrough: alu_o=0, alu_z=1, alu_n=0 → mem_z=1, mem_n=0. Then alu_o=0xFFFFFFFF, alu_n=1 → mem_n=1, mem_z=0.
